imem_loader: RTL and testbench

- Write-side counterpart of the byte-addressed instruction memory used by the RISC-V core.
- Accepts 32-bit program words from the host/bridge over a valid/ready stream and serialises each word into four byte writes on the memory's write port.
- Holds the CPU in reset until a load session completes.
- Sits between the APF bridge command decode and the instruction memory / CPU reset input.

---
 rtl/imem_pkg.sv | 44 ++++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/imem_loader.sv | 188 ++++++++++++++++++
 tb/tb_imem_loader.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory loader.
package imem_pkg;

    // Load session states.
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        RUN
    } state_e;

    localparam int BYTES_PER_WORD = 4;

    // Reasons a word may be dropped at acceptance. Declaration order is the
    // priority order: a word that is both misaligned and out of range is
    // reported as misaligned only.
    typedef enum logic [1:0] {
        DROP_NONE,
        DROP_MISALIGN,
        DROP_RANGE
    } drop_e;

    // Decide whether a word offered at byte offset addr may be written into a
    // memory of 2^addr_width bytes.
    function automatic drop_e classify(input logic [31:0] addr, input int unsigned addr_width);
        if (addr[1:0] != 2'b00) begin
            return DROP_MISALIGN;
        end
        if ((addr >> addr_width) != 32'd0) begin
            return DROP_RANGE;
        end
        return DROP_NONE;
    endfunction

    // Pick the byte written at offset idx within a word. Without swap the
    // least significant byte lands at offset 0; with swap the most significant.
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] idx,
                                             input bit swap);
        logic [1:0] lane;
        lane = swap ? ~idx : idx;
        return word[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty and a synchronous flush.
module sync_fifo #(
    parameter int WIDTH = 42,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array, written on every accepted push.
    // NOTE: the array has no reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams 32-bit program words from the host into the byte-wide instruction
// memory write port and holds the CPU in reset until a load session finishes.
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH = 4,
    parameter bit BYTE_SWAP  = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load_start,
    input  logic                  load_end,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [31:0]           wr_addr,
    input  logic [31:0]           wr_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  cpu_reset_n,
    output logic                  loading,
    output logic                  done,
    output logic                  err_misalign,
    output logic                  err_range,
    output logic [ADDR_WIDTH-2:0] word_count
);

    localparam int ENTRY_W = ADDR_WIDTH + 32;

    state_e state;
    state_e state_next;

    logic                  start_session;
    logic                  accept;
    drop_e                 drop;
    logic                  push;
    logic                  pop;
    logic                  active;
    logic [ENTRY_W-1:0]    fifo_dout;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [31:0]           head_data;

    // Byte engine: after byte 0 is issued straight from the FIFO head, it
    // holds the word and issues offsets 1..3 from these registers.
    logic                  eng_busy;
    logic [1:0]            eng_idx;
    logic [ADDR_WIDTH-3:0] eng_word_addr;
    logic [31:0]           eng_data;
    logic                  eng_last;

    assign start_session = load_start && (state == IDLE || state == RUN);
    assign active        = (state == LOAD) || (state == DRAIN);
    assign accept        = wr_valid && wr_ready;
    assign drop          = classify(wr_addr, ADDR_WIDTH);
    assign push          = accept && (drop == DROP_NONE);
    assign head_addr     = fifo_dout[ENTRY_W-1:32];
    assign head_data     = fifo_dout[31:0];
    assign pop           = active && !eng_busy && !fifo_empty;
    assign eng_last      = eng_busy && (eng_idx == 2'(BYTES_PER_WORD - 1));

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (start_session),
        .push    (push),
        .pop     (pop),
        .din     ({wr_addr[ADDR_WIDTH-1:0], wr_data}),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Session state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Session next-state and status outputs. DRAIN finishes as the last byte
    // is written, so done rises on the cycle right after it.
    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        state_next  = state;
        wr_ready    = 1'b0;
        loading     = 1'b0;
        done        = 1'b0;
        cpu_reset_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (load_start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                wr_ready = !fifo_full;
                loading  = 1'b1;
                if (load_end) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                loading = 1'b1;
                if (fifo_empty && (!eng_busy || eng_last)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                done        = 1'b1;
                cpu_reset_n = 1'b1;
                if (load_start) begin
                    state_next = LOAD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Write port: byte 0 comes from the FIFO head on the pop cycle, bytes 1..3
    // from the engine, so consecutive words keep mem_we high continuously.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (pop) begin
            mem_we    = 1'b1;
            mem_addr  = head_addr;
            mem_wdata = byte_lane(head_data, 2'd0, BYTE_SWAP);
        end else if (eng_busy) begin
            mem_we    = 1'b1;
            mem_addr  = {eng_word_addr, eng_idx};
            mem_wdata = byte_lane(eng_data, eng_idx, BYTE_SWAP);
        end
    end

    // Byte engine sequencing; the base is word aligned, so offsets are
    // formed by concatenation rather than addition.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eng_busy      <= 1'b0;
            eng_idx       <= 2'd0;
            eng_word_addr <= '0;
            eng_data      <= '0;
        end else if (pop) begin
            eng_busy      <= 1'b1;
            eng_idx       <= 2'd1;
            eng_word_addr <= head_addr[ADDR_WIDTH-1:2];
            eng_data      <= head_data;
        end else if (eng_busy) begin
            eng_idx <= eng_idx + 2'd1;
            if (eng_last) begin
                eng_busy <= 1'b0;
            end
        end
    end

    // Sticky drop flags and the saturating count of completed words.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_misalign <= 1'b0;
            err_range    <= 1'b0;
            word_count   <= '0;
        end else if (start_session) begin
            err_misalign <= 1'b0;
            err_range    <= 1'b0;
            word_count   <= '0;
        end else begin
            if (accept && drop == DROP_MISALIGN) begin
                err_misalign <= 1'b1;
            end
            if (accept && drop == DROP_RANGE) begin
                err_range <= 1'b1;
            end
            if (eng_last && word_count != '1) begin
                word_count <= word_count + (ADDR_WIDTH-1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized bench for imem_loader with a byte-level write model.
module tb_imem_loader;

    localparam int AW = 10;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } byte_wr_t;

    logic          clk;
    logic          reset_n;
    logic          load_start;
    logic          load_end;
    logic          wr_valid;
    logic          wr_ready;
    logic [31:0]   wr_addr;
    logic [31:0]   wr_data;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          cpu_reset_n;
    logic          loading;
    logic          done;
    logic          err_misalign;
    logic          err_range;
    logic [AW-2:0] word_count;

    int checks = 0;
    int errors = 0;

    // Reference model: expected byte writes in order, plus session status.
    byte_wr_t      exp_q[$];
    bit            m_misalign = 1'b0;
    bit            m_range    = 1'b0;
    int            m_words    = 0;

    int            wr_seen  = 0;
    int            run_len  = 0;
    int            last_run = 0;
    int            stalls   = 0;
    logic [AW-1:0] last_addr = '0;

    imem_loader #(
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (4),
        .BYTE_SWAP  (1'b0)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_start   (load_start),
        .load_end     (load_end),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_reset_n  (cpu_reset_n),
        .loading      (loading),
        .done         (done),
        .err_misalign (err_misalign),
        .err_range    (err_range),
        .word_count   (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Model of one accepted word: dropped words only raise a flag, kept words
    // become four little-endian byte writes at consecutive addresses.
    task automatic model_accept(input logic [31:0] a, input logic [31:0] d);
        if (a % 4 != 0) begin
            m_misalign = 1'b1;
        end else if (a >= 32'd1024) begin
            m_range = 1'b1;
        end else begin
            for (int k = 0; k < 4; k++) begin
                byte_wr_t e;
                e.addr = AW'(a + 32'(k));
                e.data = 8'((d >> (8 * k)) & 32'hFF);
                exp_q.push_back(e);
            end
            m_words++;
        end
    endtask

    // Byte-write monitor: compares every write against the model queue.
    always @(negedge clk) begin : monitor
        byte_wr_t e;
        if (mem_we === 1'b1) begin
            wr_seen++;
            run_len++;
            last_addr = mem_addr;
            check("we_in_session", loading, 1);
            if (exp_q.size() == 0) begin
                check("unexpected_write", mem_we, 0);
            end else begin
                e = exp_q.pop_front();
                check("mem_addr", mem_addr, e.addr);
                check("mem_wdata", mem_wdata, e.data);
            end
        end else begin
            if (run_len != 0) begin
                last_run = run_len;
            end
            run_len = 0;
        end
    end

    task automatic start_pulse(input bit with_end);
        load_start = 1'b1;
        load_end   = with_end;
        m_misalign = 1'b0;
        m_range    = 1'b0;
        m_words    = 0;
        @(negedge clk);
        load_start = 1'b0;
        load_end   = 1'b0;
    endtask

    task automatic end_pulse();
        load_end = 1'b1;
        @(negedge clk);
        load_end = 1'b0;
    endtask

    // Offer one word and hold it until accepted; wr_valid stays high afterwards.
    task automatic send(input logic [31:0] a, input logic [31:0] d, input bit with_end);
        int n;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        n = 0;
        while (wr_ready !== 1'b1 && n < 100) begin
            stalls++;
            @(negedge clk);
            n++;
        end
        if (wr_ready !== 1'b1) begin
            check("send_ready", wr_ready, 1);
            wr_valid = 1'b0;
        end else begin
            model_accept(a, d);
            load_end = with_end;
            @(negedge clk);
            load_end = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        wr_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("done_rise", done, 1);
    endtask

    initial begin
        logic [7:0]  beef_bytes [4];
        logic [31:0] a;
        int          rec;
        int          kind;
        int          nbytes;

        beef_bytes[0] = 8'hEF;
        beef_bytes[1] = 8'hBE;
        beef_bytes[2] = 8'hAD;
        beef_bytes[3] = 8'hDE;

        reset_n    = 1'b0;
        load_start = 1'b0;
        load_end   = 1'b0;
        wr_valid   = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_cpu_reset_n", cpu_reset_n, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_done", done, 0);
        check("rst_loading", loading, 0);
        check("rst_word_count", word_count, 0);
        check("rst_errors", {err_misalign, err_range}, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_wr_ready", wr_ready, 0);
        check("idle_cpu_reset_n", cpu_reset_n, 0);
        end_pulse();
        check("idle_load_end_ignored", loading, 0);

        // Single word: exact byte order and t+1..t+4 latency.
        start_pulse(1'b0);
        check("t1_loading", loading, 1);
        check("t1_wr_ready", wr_ready, 1);
        check("t1_cpu_held", cpu_reset_n, 0);
        send(32'h0, 32'hDEADBEEF, 1'b0);
        wr_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("t1_we", mem_we, 1);
            check("t1_addr", mem_addr, k);
            check("t1_byte", mem_wdata, beef_bytes[k]);
            @(negedge clk);
        end
        check("t1_we_off", mem_we, 0);
        end_pulse();
        wait_done();
        check("t1_cpu_run", cpu_reset_n, 1);
        check("t1_word_count", word_count, 1);
        check("t1_loading_off", loading, 0);

        // Eight back-to-back words: back-pressure and 32 continuous writes.
        start_pulse(1'b0);
        check("t2_cpu_falls", cpu_reset_n, 0);
        check("t2_count_clear", word_count, 0);
        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            send(32'(4 * i), $urandom, 1'b0);
        end
        wr_valid = 1'b0;
        end_pulse();
        wait_done();
        @(negedge clk);
        check("t2_backpressure", stalls > 0, 1);
        check("t2_continuous_we", last_run, 32);
        check("t2_last_addr", last_addr, 10'h01F);
        check("t2_word_count", word_count, 8);

        // Dropped words; load_start together with load_end from RUN.
        start_pulse(1'b1);
        check("t3_start_wins", loading, 1);
        send(32'h402, $urandom, 1'b0);
        check("t3_prio_misalign", err_misalign, 1);
        check("t3_prio_range", err_range, 0);
        send(32'h002, $urandom, 1'b0);
        send(32'h400, $urandom, 1'b0);
        rec = wr_seen;
        idle(6);
        check("t3_no_writes", wr_seen, rec);
        check("t3_err_misalign", err_misalign, 1);
        check("t3_err_range", err_range, 1);
        end_pulse();
        wait_done();
        check("t3_word_count", word_count, 0);
        start_pulse(1'b0);
        check("t3_errs_cleared", {err_misalign, err_range}, 0);

        // Drain with three words queued; load_end shares the last handshake.
        send(32'h3F0, $urandom, 1'b0);
        send(32'h3F4, $urandom, 1'b0);
        send(32'h3F8, $urandom, 1'b0);
        send(32'h3FC, $urandom, 1'b1);
        wr_valid = 1'b0;
        nbytes = 0;
        while (mem_we === 1'b1 && nbytes < 64) begin
            check("t4_loading", loading, 1);
            check("t4_done_low", done, 0);
            nbytes++;
            @(negedge clk);
        end
        check("t4_drain_bytes", nbytes, 13);
        check("t4_done_next", done, 1);
        check("t4_cpu_run", cpu_reset_n, 1);
        check("t4_word_count", word_count, 4);

        // Randomized session with gaps, drops and an ignored load_start.
        start_pulse(1'b0);
        for (int i = 0; i < 24; i++) begin
            kind = int'($urandom_range(0, 7));
            if (kind == 0) begin
                a = ($urandom_range(0, 255) << 2) | $urandom_range(1, 3);
            end else if (kind == 1) begin
                a = 32'd1024 + ($urandom_range(0, 4000) << 2);
            end else begin
                a = $urandom_range(0, 255) << 2;
            end
            if (i == 12) begin
                wr_valid   = 1'b0;
                load_start = 1'b1;
                @(negedge clk);
                load_start = 1'b0;
            end
            idle(int'($urandom_range(0, 2)));
            send(a, $urandom, 1'b0);
        end
        wr_valid = 1'b0;
        end_pulse();
        wait_done();
        check("t5_word_count", word_count, m_words);
        check("t5_err_misalign", err_misalign, m_misalign);
        check("t5_err_range", err_range, m_range);
        @(negedge clk);
        check("t5_queue_empty", exp_q.size(), 0);

        // Reset on the second byte of a word with another word queued.
        start_pulse(1'b0);
        send(32'h040, $urandom, 1'b0);
        send(32'h044, $urandom, 1'b0);
        wr_valid = 1'b0;
        check("t6_second_byte", mem_addr, 10'h041);
        reset_n = 1'b0;
        #1;
        check("t6_we_drops", mem_we, 0);
        check("t6_cpu_held", cpu_reset_n, 0);
        check("t6_idle", {loading, done, wr_ready}, 0);
        check("t6_count_clear", word_count, 0);
        exp_q.delete();
        m_misalign = 1'b0;
        m_range    = 1'b0;
        m_words    = 0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("t6_after_reset_idle", loading, 0);
        start_pulse(1'b0);
        rec = wr_seen;
        idle(6);
        check("t6_fifo_flushed", wr_seen, rec);
        send(32'h080, $urandom, 1'b1);
        wr_valid = 1'b0;
        wait_done();
        check("t6_word_count", word_count, 1);
        @(negedge clk);
        check("t6_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
